// File: rtl/rr_grant_sched_8_pkg.sv
// Shared types and constants for the 8-way round-robin grant scheduler.
package rr_grant_sched_8_pkg;
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;
endpackage

// File: rtl/rr_grant_sched_8_if.sv
// Requester/grant bundle between the requesting blocks (master) and the scheduler (slave).
interface rr_grant_sched_8_if;
  logic                                        en;
  logic [rr_grant_sched_8_pkg::N_REQ-1:0]      req;
  logic [rr_grant_sched_8_pkg::N_REQ-1:0]      gnt;
  logic [rr_grant_sched_8_pkg::IDX_W-1:0]      gnt_idx;
  logic                                        gnt_valid;
  logic [rr_grant_sched_8_pkg::IDX_W-1:0]      ptr;

  modport master (output en, req, input  gnt, gnt_idx, gnt_valid, ptr);
  modport slave  (input  en, req, output gnt, gnt_idx, gnt_valid, ptr);
endinterface

// File: rtl/rr_grant_sched_8_dec.sv
// Index + enable to one-hot decoder; bit i set when i_idx == i and i_en.
module rr_idx_decoder
  import rr_grant_sched_8_pkg::*;
(
  input  logic [IDX_W-1:0] i_idx,
  input  logic             i_en,
  output logic [N_REQ-1:0] o_onehot
);
  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot[i_idx] = 1'b1;
  end
endmodule

// File: rtl/rr_grant_sched_8.sv
// 8-requester round-robin scheduler: one owner at a time, held until release or
// hold-limit expiry, with atomic one-hot to one-hot handover.
module rr_grant_sched_8
  import rr_grant_sched_8_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic                clk,
  input  logic                rst,
  rr_grant_sched_8_if.slave   bus
);
  state_e             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [IDX_W-1:0]   r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;

  logic [N_REQ-1:0]   w_sreq;
  logic [IDX_W-1:0]   w_cand;
  logic [IDX_W-1:0]   w_win;
  logic               w_found;
  logic               w_expire;

  // Owner is masked while OWN: harmless on release (its req is 0), needed on expiry.
  always_comb begin
    w_sreq  = bus.req;
    if (r_state == OWN) w_sreq[r_idx] = 1'b0;
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_cand = r_ptr + IDX_W'(k);
      if (!w_found && w_sreq[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  assign w_expire = (MAX_HOLD != 0) && (r_cnt == CNT_W'(MAX_HOLD));

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (bus.en && w_found) begin
          w_state_nxt = OWN;
          w_idx_nxt   = w_win;
          w_ptr_nxt   = w_win + 1'b1;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      OWN: begin
        if (!bus.req[r_idx] || w_expire) begin
          if (bus.en && w_found) begin
            w_idx_nxt = w_win;
            w_ptr_nxt = w_win + 1'b1;
            w_cnt_nxt = CNT_W'(1);
          end else if (!bus.req[r_idx]) begin
            w_state_nxt = IDLE;
          end else if (bus.en) begin
            // Expiry with nobody waiting: re-grant the same owner.
            w_ptr_nxt = r_idx + 1'b1;
            w_cnt_nxt = CNT_W'(1);
          end
        end else if (r_cnt != '1) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign bus.gnt_idx   = r_idx;
  assign bus.gnt_valid = (r_state == OWN);
  assign bus.ptr       = r_ptr;

  rr_idx_decoder u_dec (
    .i_idx    (r_idx),
    .i_en     (r_state == OWN),
    .o_onehot (bus.gnt)
  );
endmodule
